// File: rtl/dsp_result_serializer.sv
// Generic single-clock FIFO with an occupancy count.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: in_rdy is low while full, decoded from the registered level only.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   core_clk,
    input  logic                   arst_n,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [W-1:0]           in_dat,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [W-1:0]           out_dat,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign in_rdy  = (level != LVL_FULL);
    assign out_vld = (level != '0);
    assign push    = in_vld && in_rdy;
    assign pop     = out_rdy && out_vld;
    assign out_dat = mem[rd_ptr];

    always_ff @(posedge core_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// Buffers DSP results and shifts each one out MSB-first as an SPI-style frame.
// Latency: frame select drops one cycle after the word reaches the FIFO head.
// Backpressure: res_ready low while the FIFO is full; pops only between frames.
module dsp_result_serializer #(
    parameter int DATA_W  = 48,
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 2
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   enable,
    input  logic                   res_valid,
    input  logic [DATA_W-1:0]      res_data,
    output logic                   res_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   busy,
    output logic                   ser_sclk,
    output logic                   ser_mosi,
    output logic                   ser_cs_n,
    output logic [2:0]             ser_oeb
);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_DONE = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] BIT_FINAL = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [DATA_W-1:0] shreg, sh_nxt;
    logic              sclk_nxt, mosi_nxt, cs_n_nxt;
    logic              div_done;
    logic              pop;
    logic              head_vld;
    logic [DATA_W-1:0] head_dat;

    sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .core_clk (wb_clk_i),
        .arst_n   (wb_rst_ni),
        .in_vld   (res_valid),
        .in_rdy   (res_ready),
        .in_dat   (res_data),
        .out_vld  (head_vld),
        .out_rdy  (pop),
        .out_dat  (head_dat),
        .level    (fifo_level)
    );

    assign busy     = (state != IDLE);
    assign div_done = (div_cnt == DIV_LAST);

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        sh_nxt    = shreg;
        sclk_nxt  = ser_sclk;
        mosi_nxt  = ser_mosi;
        cs_n_nxt  = ser_cs_n;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (enable && head_vld) begin
                    pop       = 1'b1;
                    sh_nxt    = head_dat;
                    mosi_nxt  = head_dat[DATA_W-1];
                    cs_n_nxt  = 1'b0;
                    bit_nxt   = '0;
                    div_nxt   = '0;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (div_done) begin
                    sclk_nxt  = 1'b1;
                    div_nxt   = '0;
                    state_nxt = SHIFT;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (!div_done) begin
                    div_nxt = div_cnt + 1'b1;
                end else begin
                    div_nxt = '0;
                    // The last low half-period is held before cs_n releases.
                    if (bit_cnt == BIT_DONE) begin
                        cs_n_nxt  = 1'b1;
                        state_nxt = GAP;
                    end else if (!ser_sclk) begin
                        sclk_nxt = 1'b1;
                    end else begin
                        sclk_nxt = 1'b0;
                        bit_nxt  = bit_cnt + 1'b1;
                        sh_nxt   = {shreg[DATA_W-2:0], 1'b0};
                        mosi_nxt = (bit_cnt == BIT_FINAL) ? 1'b0 : shreg[DATA_W-2];
                    end
                end
            end
            GAP: begin
                if (div_done) begin
                    div_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                div_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            ser_sclk <= 1'b0;
            ser_mosi <= 1'b0;
            ser_cs_n <= 1'b1;
            ser_oeb  <= 3'b111;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= sh_nxt;
            ser_sclk <= sclk_nxt;
            ser_mosi <= mosi_nxt;
            ser_cs_n <= cs_n_nxt;
            ser_oeb  <= enable ? 3'b000 : 3'b111;
        end
    end
endmodule

// File: tb/tb_dsp_result_serializer.sv
// Bench for dsp_result_serializer: two builds (CLK_DIV=2 and CLK_DIV=1) share one stimulus;
// a pad-level frame decoder plus a word queue act as the reference for the selected build.
module tb_dsp_result_serializer;
    localparam int DW = 48;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          res_valid;
    logic [DW-1:0] res_data;

    logic       a_ready, a_busy, a_sclk, a_mosi, a_cs_n;
    logic [2:0] a_level, a_oeb;
    logic       b_ready, b_busy, b_sclk, b_mosi, b_cs_n;
    logic [2:0] b_level, b_oeb;

    logic       sel;
    logic       m_ready, m_busy, m_sclk, m_mosi, m_cs_n;
    logic [2:0] m_level, m_oeb;

    assign m_ready = sel ? b_ready : a_ready;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_sclk  = sel ? b_sclk  : a_sclk;
    assign m_mosi  = sel ? b_mosi  : a_mosi;
    assign m_cs_n  = sel ? b_cs_n  : a_cs_n;
    assign m_level = sel ? b_level : a_level;
    assign m_oeb   = sel ? b_oeb   : a_oeb;

    dsp_result_serializer #(.DATA_W(DW), .DEPTH(4), .CLK_DIV(2)) dut_a (
        .wb_clk_i (clk), .wb_rst_ni (rst_n), .enable (enable),
        .res_valid (res_valid), .res_data (res_data), .res_ready (a_ready),
        .fifo_level (a_level), .busy (a_busy), .ser_sclk (a_sclk),
        .ser_mosi (a_mosi), .ser_cs_n (a_cs_n), .ser_oeb (a_oeb)
    );

    dsp_result_serializer #(.DATA_W(DW), .DEPTH(4), .CLK_DIV(1)) dut_b (
        .wb_clk_i (clk), .wb_rst_ni (rst_n), .enable (enable),
        .res_valid (res_valid), .res_data (res_data), .res_ready (b_ready),
        .fifo_level (b_level), .busy (b_busy), .ser_sclk (b_sclk),
        .ser_mosi (b_mosi), .ser_cs_n (b_cs_n), .ser_oeb (b_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference state: words accepted but not yet framed, plus the frame decoder.
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] cur_exp, got, last_word;
    logic          in_frame, p_sclk, p_cs_n, en_edge;
    int            nbits, low_len, hi_len, sclk_hi, last_gap, frames_done, div;

    typedef struct {
        logic          en;
        logic          vld;
        logic [DW-1:0] dat;
        logic          exp_rdy;
        logic [2:0]    exp_lvl;
        logic [2:0]    exp_oeb;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic clr_model(input int d);
        exp_q.delete();
        in_frame = 1'b0; p_sclk = 1'b0; p_cs_n = 1'b1; en_edge = 1'b0;
        nbits = 0; low_len = 0; hi_len = 0; sclk_hi = 0; last_gap = 0;
        frames_done = 0; div = d; got = '0;
    endtask

    task automatic monitor();
        if (p_cs_n && !m_cs_n) begin
            chk("start_enable", longint'(en_edge), 1);
            chk("start_expected", longint'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
            in_frame = 1'b1; nbits = 0; got = '0; low_len = 0; last_gap = hi_len;
        end
        if (!p_cs_n && m_cs_n && in_frame) begin
            chk("frame_bits", longint'(nbits), DW);
            chk("frame_word", longint'(got), longint'(cur_exp));
            chk("cs_low_cycles", longint'(low_len), longint'(97 * div));
            last_word = got; frames_done++; in_frame = 1'b0; hi_len = 0;
        end
        if (p_sclk && !m_sclk) chk("sclk_high", longint'(sclk_hi), longint'(div));
        sclk_hi = m_sclk ? sclk_hi + 1 : 0;
        if (!m_cs_n) begin
            low_len++;
            chk("busy_in_frame", longint'(m_busy), 1);
            if (m_sclk && !p_sclk) begin
                got = {got[DW-2:0], m_mosi};
                nbits++;
            end
        end else begin
            hi_len++;
            chk("idle_pads", longint'({m_sclk, m_mosi}), 0);
        end
        chk("fifo_level", longint'(m_level), longint'(exp_q.size()));
        chk("res_ready", longint'(m_ready), longint'(exp_q.size() < 4));
        chk("ser_oeb", longint'(m_oeb), en_edge ? 0 : 7);
        p_sclk = m_sclk; p_cs_n = m_cs_n;
    endtask

    // Inputs are already driven at a falling edge; clock once and check.
    task automatic step();
        en_edge = enable;
        if (res_valid && m_ready) exp_q.push_back(res_data);
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic reset_check();
        #1;
        chk("rst_level", longint'(m_level), 0);
        chk("rst_ready", longint'(m_ready), 1);
        chk("rst_busy", longint'(m_busy), 0);
        chk("rst_sclk", longint'(m_sclk), 0);
        chk("rst_mosi", longint'(m_mosi), 0);
        chk("rst_cs_n", longint'(m_cs_n), 1);
        chk("rst_oeb", longint'(m_oeb), 7);
    endtask

    task automatic do_reset(input int d);
        enable = 1'b0; res_valid = 1'b0; res_data = '0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        reset_check();
        clr_model(d);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames_done < n && k < budget) begin
            step();
            k++;
        end
        chk("wait_frames", longint'(frames_done >= n), 1);
    endtask

    task automatic wait_bits(input int n, input int budget);
        int k = 0;
        while (!(in_frame && nbits >= n) && k < budget) begin
            step();
            k++;
        end
        chk("wait_bits", longint'(in_frame && nbits >= n), 1);
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        res_valid = 1'b1; res_data = w;
        step();
        res_valid = 1'b0;
    endtask

    task automatic run_random(input int cycles);
        logic [63:0] r;
        int k;
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            res_valid = ($urandom_range(0, 3) == 0);
            r = {$urandom(), $urandom()};
            res_data = r[DW-1:0];
            step();
        end
        enable = 1'b1; res_valid = 1'b0;
        k = 0;
        while ((exp_q.size() != 0 || in_frame || m_busy) && k < 3000) begin
            step();
            k++;
        end
        chk("drain_empty", longint'(exp_q.size()) + longint'(in_frame), 0);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 48'h0123_4567_89AB, 1'b1, 3'd1, 3'b111};
        tbl[1] = '{1'b0, 1'b1, 48'hFEDC_BA98_7654, 1'b1, 3'd2, 3'b111};
        tbl[2] = '{1'b0, 1'b1, 48'h8000_0000_0001, 1'b1, 3'd3, 3'b111};
        tbl[3] = '{1'b0, 1'b1, 48'h5555_AAAA_5555, 1'b0, 3'd4, 3'b111};
        tbl[4] = '{1'b0, 1'b1, 48'hDEAD_BEEF_0BAD, 1'b0, 3'd4, 3'b111};
        tbl[5] = '{1'b0, 1'b0, 48'h0,              1'b0, 3'd4, 3'b111};
        tbl[6] = '{1'b1, 1'b1, 48'h3C3C_C3C3_0F0F, 1'b1, 3'd3, 3'b000};
        tbl[7] = '{1'b1, 1'b1, 48'h3C3C_C3C3_0F0F, 1'b0, 3'd4, 3'b000};
        tbl[8] = '{1'b1, 1'b0, 48'h0,              1'b0, 3'd4, 3'b000};

        sel = 1'b0; rst_n = 1'b1; enable = 1'b0; res_valid = 1'b0; res_data = '0;
        clr_model(2);
        do_reset(2);

        // Single frame with a known pattern.
        enable = 1'b1;
        push_word(48'hA5A5_0000_FFFF);
        wait_frames(1, 400);
        chk("t1_word", longint'(last_word), longint'(48'hA5A5_0000_FFFF));

        // Fill with enable low, overflow attempt, then enable with a held offer.
        do_reset(2);
        for (int i = 0; i < 9; i++) begin
            enable = tbl[i].en; res_valid = tbl[i].vld; res_data = tbl[i].dat;
            step();
            chk("tbl_level", longint'(m_level), longint'(tbl[i].exp_lvl));
            chk("tbl_ready", longint'(m_ready), longint'(tbl[i].exp_rdy));
            chk("tbl_oeb", longint'(m_oeb), longint'(tbl[i].exp_oeb));
        end
        res_valid = 1'b0;
        wait_frames(5, 2000);
        chk("t2_gap_b2b", longint'(last_gap), 3);

        // Drop enable mid-frame: frame finishes, queued words stay.
        push_word(48'h1111_2222_3333);
        push_word(48'h4444_5555_6666);
        push_word(48'h7777_8888_9999);
        wait_bits(20, 300);
        enable = 1'b0;
        step();
        chk("t4_oeb", longint'(m_oeb), 7);
        chk("t4_level", longint'(m_level), 2);
        wait_frames(6, 400);
        for (int i = 0; i < 50; i++) step();
        chk("t4_level_after", longint'(m_level), 2);
        chk("t4_no_frame", longint'(in_frame), 0);

        // Reset mid-frame discards everything.
        enable = 1'b1;
        wait_bits(30, 400);
        #2 rst_n = 1'b0;
        reset_check();
        clr_model(2);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) step();
        chk("t5_no_frame", longint'(frames_done) + longint'(in_frame), 0);

        run_random(3000);

        // Fast build: two queued words, CLK_DIV=1 timing.
        sel = 1'b1;
        do_reset(1);
        push_word(48'hC0FF_EE00_1234);
        push_word(48'h0000_0000_0001);
        enable = 1'b1;
        wait_frames(2, 400);
        chk("t6_gap", longint'(last_gap), 2);
        chk("t6_word", longint'(last_word), 1);

        run_random(1500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
